// File: rtl/dbg_pkg.sv
// ============================================================================
// Package     : dbg_pkg
// Description : Definitions shared by the MIPS debug frame serializer and the
//               MicroBlaze debug interface: select encodings, serializer
//               state encoding and frame width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dbg_pkg;

  // Width of one frame as seen by the debug interface
  localparam int NB_FRAME = 32;

  // Request select encodings (6-bit request code)
  localparam logic [5:0] SEL_NONE       = 6'b111111;
  localparam logic [5:0] SEL_MEM_DATA   = 6'b100000;
  localparam logic [5:0] SEL_MEM_INSTR  = 6'b100001;
  localparam logic [5:0] SEL_PC         = 6'b100010;
  localparam logic [5:0] SEL_LATCH_BASE = 6'b100100;

  // Serializer state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MEM   = 2'd2,
    ST_EOD   = 2'd3
  } state_e;

  // Latch requests occupy 1001xx and 1010xx (strips 0..7)
  function automatic logic is_latch_sel(input logic [5:0] sel);
    return (sel[5:4] == 2'b10) && ((sel[3:2] == 2'b01) || (sel[3:2] == 2'b10));
  endfunction

endpackage

`default_nettype wire

// File: rtl/debug_latch_mux.sv
// ============================================================================
// Module      : debug_latch_mux
// Description : Combinational N_LATCH:1 selector of NB_LATCH-bit pipeline
//               latch strips. Strip 0 sits in the LSBs of the bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_latch_mux #(
  parameter int NB_LATCH = 96,
  parameter int N_LATCH  = 8,
  parameter int NB_IDX   = $clog2(N_LATCH)
) (
  input  logic [N_LATCH*NB_LATCH-1:0] i_latch_bus,
  input  logic [NB_IDX-1:0]           i_index,
  output logic [NB_LATCH-1:0]         o_strip
);

  logic [NB_LATCH-1:0] w_strips [N_LATCH];

  // Split the flat bus into individually addressable strips
  for (genvar g = 0; g < N_LATCH; g++) begin : g_strip
    assign w_strips[g] = i_latch_bus[g*NB_LATCH +: NB_LATCH];
  end

  assign o_strip = w_strips[i_index];

endmodule

`default_nettype wire

// File: rtl/debug_frame_serializer.sv
// ============================================================================
// Module      : debug_frame_serializer
// Description : Answers debug-interface data requests. Decodes the one-cycle
//               request select pulse and streams 1 frame (register, PC,
//               memory) or a 3-frame latch strip (MSB first), followed by a
//               one-cycle end-of-data strobe. Also holds the sticky
//               end-of-program flag.
// Config      : DBG_SERIALIZER_MEM_EN - when defined, memory requests
//               (100000/100001) drive the read enables and pass i_mem_data
//               through; otherwise they are treated as unknown codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_frame_serializer
  import dbg_pkg::*;
#(
  parameter int NB_LATCH  = 96,
  parameter int N_FRAMES  = 3,
  parameter int N_LATCH   = 8,
  parameter int NB_SELECT = 6
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [NB_SELECT-1:0]         i_request_select,
  input  logic                         i_soft_reset,
  input  logic                         i_halt,
  input  logic [NB_FRAME-1:0]          i_reg_data,
  input  logic [NB_FRAME-1:0]          i_pc,
  input  logic [N_LATCH*NB_LATCH-1:0]  i_latch_bus,
  input  logic [NB_FRAME-1:0]          i_mem_data,
  output logic [4:0]                   o_reg_addr,
  output logic                         o_mem_re_data,
  output logic                         o_mem_re_instr,
  output logic [NB_FRAME-1:0]          o_frame,
  output logic                         o_eod,
  output logic                         o_eop
);

  localparam int         NB_IDX     = $clog2(N_LATCH);
  localparam logic [1:0] C_CNT_LOAD = 2'(N_FRAMES - 1);

  state_e              state_q,  state_d;
  logic [NB_LATCH-1:0] buffer_q, buffer_d;
  logic [1:0]          count_q,  count_d;
  logic                eop_q;

  logic [NB_LATCH-1:0] w_strip;
  logic [3:0]          w_strip_off;
  logic [NB_IDX-1:0]   w_strip_idx;
  logic                w_request;

  // Latch strips start at 1001_00, so rebase the low nibble to a 0-based index
  assign w_strip_off = i_request_select[3:0] - 4'd4;
  assign w_strip_idx = w_strip_off[NB_IDX-1:0];
  assign w_request   = (state_q == ST_IDLE) && (i_request_select != SEL_NONE);

  debug_latch_mux #(
    .NB_LATCH (NB_LATCH),
    .N_LATCH  (N_LATCH)
  ) u_latch_mux (
    .i_latch_bus (i_latch_bus),
    .i_index     (w_strip_idx),
    .o_strip     (w_strip)
  );

  // Next-state decode: request dispatch in IDLE, frame sequencing elsewhere
  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (w_request) begin
          if (!i_request_select[5]) begin
            buffer_d = {i_reg_data, {(NB_LATCH-NB_FRAME){1'b0}}};
            count_d  = 2'd0;
            state_d  = ST_SHIFT;
          end else if (i_request_select == SEL_PC) begin
            buffer_d = {i_pc, {(NB_LATCH-NB_FRAME){1'b0}}};
            count_d  = 2'd0;
            state_d  = ST_SHIFT;
`ifdef DBG_SERIALIZER_MEM_EN
          end else if ((i_request_select == SEL_MEM_DATA) ||
                       (i_request_select == SEL_MEM_INSTR)) begin
            state_d  = ST_MEM;
`endif
          end else if (is_latch_sel(i_request_select)) begin
            buffer_d = w_strip;
            count_d  = C_CNT_LOAD;
            state_d  = ST_SHIFT;
          end else begin
            // Unrecognised code: acknowledge with an empty stream
            state_d  = ST_EOD;
          end
        end
      end
      ST_SHIFT: begin
        if (count_q == 2'd0) begin
          state_d  = ST_EOD;
        end else begin
          buffer_d = buffer_q << NB_FRAME;
          count_d  = count_q - 2'd1;
        end
      end
`ifdef DBG_SERIALIZER_MEM_EN
      ST_MEM:   state_d = ST_EOD;
`endif
      ST_EOD:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (i_soft_reset) begin
      state_d  = ST_IDLE;
      buffer_d = '0;
      count_d  = 2'd0;
    end
  end

  // Serializer state, shift buffer and frame counter
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      buffer_q <= '0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      count_q  <= count_d;
    end
  end

  // Sticky end-of-program; a soft reset overrides a coincident halt
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      eop_q <= 1'b0;
    end else if (i_soft_reset) begin
      eop_q <= 1'b0;
    end else if (i_halt) begin
      eop_q <= 1'b1;
    end
  end

  assign o_reg_addr = i_request_select[4:0];
  assign o_eod      = (state_q == ST_EOD);
  assign o_eop      = eop_q;

`ifdef DBG_SERIALIZER_MEM_EN
  assign o_mem_re_data  = w_request && (i_request_select == SEL_MEM_DATA);
  assign o_mem_re_instr = w_request && (i_request_select == SEL_MEM_INSTR);

  // Frame output: shift buffer head, memory pass-through, otherwise zero
  always_comb begin
    o_frame = '0;
    if (state_q == ST_SHIFT) begin
      o_frame = buffer_q[NB_LATCH-1 -: NB_FRAME];
    end else if (state_q == ST_MEM) begin
      o_frame = i_mem_data;
    end
  end
`else
  logic w_unused_mem;

  assign o_mem_re_data  = 1'b0;
  assign o_mem_re_instr = 1'b0;
  assign w_unused_mem   = ^i_mem_data;

  // Frame output: shift buffer head, otherwise zero
  always_comb begin
    o_frame = '0;
    if (state_q == ST_SHIFT) begin
      o_frame = buffer_q[NB_LATCH-1 -: NB_FRAME];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_debug_frame_serializer.sv
// ============================================================================
// Module      : tb_debug_frame_serializer
// Description : Directed self-checking bench for debug_frame_serializer.
//               Expectations follow DBG_SERIALIZER_MEM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_frame_serializer;

  localparam int NB_FRAME = 32;
  localparam int NB_LATCH = 96;
  localparam int N_LATCH  = 8;

  logic                        i_clock;
  logic                        i_reset;
  logic [5:0]                  i_request_select;
  logic                        i_soft_reset;
  logic                        i_halt;
  logic [NB_FRAME-1:0]         i_reg_data;
  logic [NB_FRAME-1:0]         i_pc;
  logic [N_LATCH*NB_LATCH-1:0] i_latch_bus;
  logic [NB_FRAME-1:0]         i_mem_data;
  logic [4:0]                  o_reg_addr;
  logic                        o_mem_re_data;
  logic                        o_mem_re_instr;
  logic [NB_FRAME-1:0]         o_frame;
  logic                        o_eod;
  logic                        o_eop;

  int checks = 0;
  int errors = 0;

  debug_frame_serializer dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_request_select (i_request_select),
    .i_soft_reset     (i_soft_reset),
    .i_halt           (i_halt),
    .i_reg_data       (i_reg_data),
    .i_pc             (i_pc),
    .i_latch_bus      (i_latch_bus),
    .i_mem_data       (i_mem_data),
    .o_reg_addr       (o_reg_addr),
    .o_mem_re_data    (o_mem_re_data),
    .o_mem_re_instr   (o_mem_re_instr),
    .o_frame          (o_frame),
    .o_eod            (o_eod),
    .o_eop            (o_eop)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here
  task automatic next_cycle();
    @(posedge i_clock);
    #1;
  endtask

  // Sample point well away from both clock edges
  task automatic settle();
    #2;
  endtask

  // Issue a latch request and check the three frames and the strobe
  task automatic run_latch(input logic [5:0] sel, input logic [95:0] strip, input string tag);
    i_request_select = sel;
    settle();
    chk_val({tag, "_T_frame"}, 96'(o_frame), 96'h0);
    next_cycle();
    i_request_select = 6'b111111;
    settle();
    chk_val({tag, "_f0"}, 96'(o_frame), 96'(strip[95:64]));
    chk_val({tag, "_f0_eod"}, 96'(o_eod), 96'h0);
    next_cycle(); settle();
    chk_val({tag, "_f1"}, 96'(o_frame), 96'(strip[63:32]));
    next_cycle(); settle();
    chk_val({tag, "_f2"}, 96'(o_frame), 96'(strip[31:0]));
    chk_val({tag, "_f2_eod"}, 96'(o_eod), 96'h0);
    next_cycle(); settle();
    chk_val({tag, "_eod"}, 96'(o_eod), 96'h1);
    chk_val({tag, "_eod_frame"}, 96'(o_frame), 96'h0);
    next_cycle(); settle();
    chk_val({tag, "_idle_eod"}, 96'(o_eod), 96'h0);
  endtask

  initial begin
    logic [95:0] strip5;
    logic [95:0] strip0;
    logic [95:0] strip7;

    strip5 = 96'hAAAA0001_BBBB0002_CCCC0003;
    strip0 = 96'h01010101_02020202_03030303;
    strip7 = 96'hF7F7F7F1_F7F7F7F2_F7F7F7F3;
    for (int i = 0; i < N_LATCH; i++) begin
      i_latch_bus[i*NB_LATCH +: NB_LATCH] = {3{32'h5A5A_0000 | 32'(i)}};
    end
    i_latch_bus[0*NB_LATCH +: NB_LATCH] = strip0;
    i_latch_bus[5*NB_LATCH +: NB_LATCH] = strip5;
    i_latch_bus[7*NB_LATCH +: NB_LATCH] = strip7;

    i_reset          = 1'b0;
    i_request_select = 6'b111111;
    i_soft_reset     = 1'b0;
    i_halt           = 1'b0;
    i_reg_data       = 32'h0;
    i_pc             = 32'h0;
    i_mem_data       = 32'h0;

    // Reset state
    repeat (2) next_cycle();
    settle();
    chk_val("rst_frame", 96'(o_frame), 96'h0);
    chk_val("rst_eod", 96'(o_eod), 96'h0);
    chk_val("rst_eop", 96'(o_eop), 96'h0);
    chk_val("rst_re_data", 96'(o_mem_re_data), 96'h0);
    chk_val("rst_re_instr", 96'(o_mem_re_instr), 96'h0);
    next_cycle();
    i_reset = 1'b1;
    repeat (2) next_cycle();

    // Latch strips: middle and both index boundaries
    run_latch(6'b101001, strip5, "latch5");
    run_latch(6'b100100, strip0, "latch0");
    run_latch(6'b101011, strip7, "latch7");

    // Register request
    i_request_select = 6'b000111;
    i_reg_data       = 32'h1234_5678;
    settle();
    chk_val("reg_addr", 96'(o_reg_addr), 96'd7);
    next_cycle();
    i_request_select = 6'b111111;
    settle();
    chk_val("reg_frame", 96'(o_frame), 96'h1234_5678);
    chk_val("reg_f_eod", 96'(o_eod), 96'h0);
    next_cycle(); settle();
    chk_val("reg_eod", 96'(o_eod), 96'h1);
    chk_val("reg_eod_frame", 96'(o_frame), 96'h0);
    next_cycle();

    // Memory requests (data then instruction)
    for (int m = 0; m < 2; m++) begin
      i_request_select = (m == 0) ? 6'b100000 : 6'b100001;
      settle();
`ifdef DBG_SERIALIZER_MEM_EN
      chk_val("mem_re_data", 96'(o_mem_re_data), 96'(m == 0));
      chk_val("mem_re_instr", 96'(o_mem_re_instr), 96'(m == 1));
      next_cycle();
      i_request_select = 6'b111111;
      i_mem_data       = 32'hDEAD_BEEF ^ 32'(m);
      settle();
      chk_val("mem_frame", 96'(o_frame), 96'(32'hDEAD_BEEF ^ 32'(m)));
      chk_val("mem_re_drop", 96'(o_mem_re_data | o_mem_re_instr), 96'h0);
      next_cycle();
      i_mem_data = 32'h0;
      settle();
      chk_val("mem_eod", 96'(o_eod), 96'h1);
`else
      chk_val("mem_off_re_data", 96'(o_mem_re_data), 96'h0);
      chk_val("mem_off_re_instr", 96'(o_mem_re_instr), 96'h0);
      next_cycle();
      i_request_select = 6'b111111;
      i_mem_data       = 32'hDEAD_BEEF;
      settle();
      chk_val("mem_off_eod", 96'(o_eod), 96'h1);
      chk_val("mem_off_frame", 96'(o_frame), 96'h0);
      i_mem_data = 32'h0;
`endif
      next_cycle();
    end

    // Unknown code; request during EOD is dropped, next one is served
    i_request_select = 6'b110000;
    next_cycle();
    i_request_select = 6'b100010;
    i_pc             = 32'h0BAD_0BAD;
    settle();
    chk_val("unk_eod", 96'(o_eod), 96'h1);
    chk_val("unk_frame", 96'(o_frame), 96'h0);
    next_cycle();
    i_request_select = 6'b000011;
    i_reg_data       = 32'h0000_3333;
    settle();
    chk_val("unk_ignored_frame", 96'(o_frame), 96'h0);
    chk_val("unk_ignored_eod", 96'(o_eod), 96'h0);
    next_cycle();
    i_request_select = 6'b111111;
    settle();
    chk_val("after_unk_frame", 96'(o_frame), 96'h0000_3333);
    next_cycle(); settle();
    chk_val("after_unk_eod", 96'(o_eod), 96'h1);
    next_cycle();

    // Halt / sticky end-of-program
    i_halt = 1'b1;
    settle();
    chk_val("eop_same_cycle", 96'(o_eop), 96'h0);
    next_cycle();
    i_halt = 1'b0;
    settle();
    chk_val("eop_set", 96'(o_eop), 96'h1);
    repeat (3) next_cycle();
    settle();
    chk_val("eop_held", 96'(o_eop), 96'h1);
    next_cycle();
    i_halt       = 1'b1;
    i_soft_reset = 1'b1;
    next_cycle();
    i_halt       = 1'b0;
    i_soft_reset = 1'b0;
    settle();
    chk_val("eop_soft_wins", 96'(o_eop), 96'h0);

    // Soft reset in mid-stream aborts without an end-of-data strobe
    i_request_select = 6'b101001;
    next_cycle();
    i_request_select = 6'b111111;
    i_soft_reset     = 1'b1;
    next_cycle();
    i_soft_reset = 1'b0;
    settle();
    chk_val("soft_abort_frame", 96'(o_frame), 96'h0);
    next_cycle(); settle();
    chk_val("soft_abort_eod", 96'(o_eod), 96'h0);
    next_cycle();

    // Asynchronous reset during a latch stream
    i_request_select = 6'b101001;
    next_cycle();
    i_request_select = 6'b111111;
    next_cycle();
    settle();
    chk_val("async_pre_frame", 96'(o_frame), 96'hBBBB0002);
    i_reset = 1'b0;
    #1;
    chk_val("async_frame", 96'(o_frame), 96'h0);
    chk_val("async_eod", 96'(o_eod), 96'h0);
    next_cycle();
    i_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk_val("async_no_eod", 96'(o_eod), 96'h0);
      next_cycle();
    end
    i_request_select = 6'b100010;
    i_pc             = 32'hCAFE_0100;
    next_cycle();
    i_request_select = 6'b111111;
    settle();
    chk_val("pc_frame", 96'(o_frame), 96'hCAFE_0100);
    next_cycle(); settle();
    chk_val("pc_eod", 96'(o_eod), 96'h1);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
